// File: rtl/frodo_hash_pkg.sv
// Shared definitions for the Frodo hash-path sampling scheduler:
// job codes, per-level matrix dimension, job length and FSM encoding.
package frodo_hash_pkg;

    localparam logic [2:0] JOB_S  = 3'b000;  // S / S' / E'
    localparam logic [2:0] JOB_E  = 3'b001;
    localparam logic [2:0] JOB_B  = 3'b100;
    localparam logic [2:0] JOB_BP = 3'b101;

    localparam logic [15:0] N_LVL1 = 16'd1344;
    localparam logic [15:0] N_LVL2 = 16'd976;
    localparam logic [15:0] N_LVL3 = 16'd640;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    function automatic logic [15:0] level_n(input logic [1:0] level);
        logic [15:0] n;
        n = 16'd0;
        case (level)
            2'b01:   n = N_LVL1;
            2'b10:   n = N_LVL2;
            2'b11:   n = N_LVL3;
            default: n = 16'd0;
        endcase
        return n;
    endfunction

    function automatic logic [15:0] job_len(input logic [2:0] job, input logic [1:0] level);
        logic [15:0] len;
        len = 16'd0;
        case (job)
            JOB_S, JOB_BP: len = level_n(level) << 3;
            JOB_E:         len = 16'd64;
            JOB_B:         len = level_n(level) << 1;
            default:       len = 16'd0;
        endcase
        return len;
    endfunction

    function automatic logic cmd_legal(input logic [2:0] job, input logic [1:0] level);
        logic job_ok;
        job_ok = (job == JOB_S) || (job == JOB_E) || (job == JOB_B) || (job == JOB_BP);
        return job_ok && (level != 2'b00);
    endfunction

endpackage

// File: rtl/hash_sched_perf.sv
// Saturating counter of RUN cycles in which no hash word was consumed.
// Only instantiated when HASH_SCHED_PERF_EN is defined.
module hash_sched_perf (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] cnt
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 16'd0;
        end else if (clr) begin
            cnt <= 16'd0;
        end else if (inc && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/hash_sample_sched.sv
// Job scheduler pacing the SHAKE-output AGU and matrix RAM writes.
// Optional HASH_SCHED_PERF_EN adds the stall_cnt performance output.
module hash_sample_sched
    import frodo_hash_pkg::*;
#(
    parameter int CNT_W = 14
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_job,
    input  logic [1:0] cmd_level,
    input  logic       cmd_abort,
    input  logic       hash_valid,
    output logic       hash_ready,
    input  logic       mem_stall,
    output logic [2:0] agu_mode,
    output logic [1:0] agu_level,
    output logic       agu_addr_clr,
    output logic       agu_add_en,
    output logic       mem_we,
    output logic       busy,
    output logic       done,
    output logic       err
`ifdef HASH_SCHED_PERF_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    // Handshakes: a command transfers when cmd_valid & cmd_ready, a hash word
    // when hash_valid & hash_ready; each hash transfer is one AGU step and one write.
    sched_state_t     state;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] len_q;
    logic [2:0]       mode_q;
    logic [1:0]       level_q;
    logic             abort_clr;
    logic             err_q;
    logic             beat;
    logic             last_beat;

    assign hash_ready   = (state == ST_RUN) && !mem_stall;
    assign beat         = hash_valid && hash_ready;
    assign last_beat    = beat && ((beat_cnt + CNT_W'(1)) == len_q);
    assign agu_add_en   = beat;
    assign mem_we       = beat;
    assign cmd_ready    = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);
    assign agu_addr_clr = (state == ST_CLEAR) || abort_clr;
    assign err          = err_q;
    assign agu_mode     = mode_q;
    assign agu_level    = level_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            len_q     <= '0;
            mode_q    <= 3'd0;
            level_q   <= 2'd0;
            abort_clr <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            abort_clr <= 1'b0;
            err_q     <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_legal(cmd_job, cmd_level)) begin
                            mode_q  <= cmd_job;
                            level_q <= cmd_level;
                            len_q   <= CNT_W'(job_len(cmd_job, cmd_level));
                            state   <= ST_CLEAR;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    beat_cnt <= '0;
                    if (cmd_abort) begin
                        abort_clr <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A beat coinciding with abort is still counted and written.
                    if (beat) beat_cnt <= beat_cnt + CNT_W'(1);
                    if (cmd_abort) begin
                        abort_clr <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (last_beat) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (cmd_abort) abort_clr <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef HASH_SCHED_PERF_EN
    hash_sched_perf u_perf (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state == ST_CLEAR),
        .inc  ((state == ST_RUN) && !beat),
        .cnt  (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_hash_sample_sched.sv
// Randomized scoreboard bench for hash_sample_sched; job outcomes are
// predicted from job/level arithmetic and the driven hash/stall pattern.
module tb_hash_sample_sched;

  localparam int W       = 64;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;
  localparam int K_ABORT = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid, cmd_ready, cmd_abort;
  logic [2:0] cmd_job;
  logic [1:0] cmd_level;
  logic       hash_valid, hash_ready, mem_stall;
  logic [2:0] agu_mode;
  logic [1:0] agu_level;
  logic       agu_addr_clr, agu_add_en, mem_we, busy, done, err;
`ifdef HASH_SCHED_PERF_EN
  logic [15:0] stall_cnt;
`endif

  hash_sample_sched #(.CNT_W(14)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_job      (cmd_job),
    .cmd_level    (cmd_level),
    .cmd_abort    (cmd_abort),
    .hash_valid   (hash_valid),
    .hash_ready   (hash_ready),
    .mem_stall    (mem_stall),
    .agu_mode     (agu_mode),
    .agu_level    (agu_level),
    .agu_addr_clr (agu_addr_clr),
    .agu_add_en   (agu_add_en),
    .mem_we       (mem_we),
    .busy         (busy),
    .done         (done),
    .err          (err)
`ifdef HASH_SCHED_PERF_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  // ---------------- clock / reset / cycle stamp ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int beats = 0;
  int steps = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_event(input int kind);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d required none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, 32'(e[63:60]));
      chk("event_cycle", 32'(cyc[15:0]), 32'(e[31:16]));
      if (kind == K_ERR) begin
        chk("err_busy", 32'(busy), 32'd0);
      end else begin
        chk("mem_we_count", beats, 32'(e[47:32]));
        chk("agu_add_en_count", steps, 32'(e[47:32]));
        chk("agu_mode", 32'(agu_mode), 32'(e[58:56]));
        chk("agu_level", 32'(agu_level), 32'(e[53:52]));
        if (kind == K_ABORT) chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef HASH_SCHED_PERF_EN
        if (kind == K_DONE) chk("stall_cnt", 32'(stall_cnt), 32'(e[15:0]));
`endif
      end
    end
  endtask

  // Monitor: counts writes per job and checks each job-ending event.
  always @(negedge clk) begin
    if (!rstn) begin
      beats = 0;
      steps = 0;
    end else begin
      if (agu_addr_clr && busy) begin
        beats = 0;
        steps = 0;
      end
      if (mem_we) beats++;
      if (agu_add_en) steps++;
      if (done) check_event(K_DONE);
      if (agu_addr_clr && !busy) check_event(K_ABORT);
      if (err) check_event(K_ERR);
    end
  end

  // ---------------- reference model ----------------
  function automatic int model_len(input logic [2:0] job, input logic [1:0] lvl);
    int n;
    n = (lvl == 2'b01) ? 1344 : (lvl == 2'b10) ? 976 : 640;
    if (job == 3'b001) return 64;
    if (job == 3'b100) return 2 * n;
    return 8 * n;
  endfunction

  function automatic logic [W-1:0] mk(input int kind, input logic [2:0] job, input logic [1:0] lvl,
                                      input int cnt, input int stamp, input int stalls);
    return {4'(kind), 1'b0, job, 2'b00, lvl, 4'h0, 16'(cnt), 16'(stamp), 16'(stalls)};
  endfunction

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // hv_mode: 0 always valid, 1 random 80%, 2 alternating starting valid.
  // st_mode: 0 none, 1 every 4th cycle, 2 random 20%.
  task automatic run_job(input logic [2:0] job, input logic [1:0] lvl, input int abort_at,
                         input int hv_mode, input int st_mode, input bit noise, input bit abort_on_cmd);
    int len, cnt, stalls, rc;
    bit hv, st, beat;
    len = model_len(job, lvl);
    cmd_valid = 1'b1;
    cmd_job   = job;
    cmd_level = lvl;
    cmd_abort = abort_on_cmd;
    step();
    cmd_valid  = 1'b0;
    cmd_abort  = 1'b0;
    hash_valid = 1'($urandom_range(0, 1));
    mem_stall  = 1'($urandom_range(0, 1));
    step();
    cnt = 0;
    stalls = 0;
    rc = 0;
    forever begin
      hv = (hv_mode == 0) ? 1'b1 : (hv_mode == 1) ? ($urandom_range(0, 4) != 0) : (rc % 2 == 0);
      st = (st_mode == 0) ? 1'b0 : (st_mode == 1) ? (cyc % 4 == 3) : ($urandom_range(0, 4) == 0);
      hash_valid = hv;
      mem_stall  = st;
      beat = hv && !st;
      if (abort_at >= 0 && cnt >= abort_at) begin
        cmd_valid = 1'b0;
        cmd_abort = 1'b1;
        if (beat) cnt++;
        exp_q.push_back(mk(K_ABORT, job, lvl, cnt, cyc + 1, 0));
        step();
        cmd_abort  = 1'b0;
        hash_valid = 1'b0;
        mem_stall  = 1'b0;
        return;
      end
      if (noise && $urandom_range(0, 7) == 0) begin
        cmd_valid = 1'b1;
        cmd_job   = 3'($urandom_range(0, 7));
        cmd_level = 2'($urandom_range(0, 3));
      end else begin
        cmd_valid = 1'b0;
      end
      if (beat) cnt++;
      else if (stalls < 65535) stalls++;
      rc++;
      if (cnt == len) begin
        exp_q.push_back(mk(K_DONE, job, lvl, len, cyc + 1, stalls));
        step();
        cmd_valid  = 1'b0;
        hash_valid = 1'($urandom_range(0, 1));
        mem_stall  = 1'($urandom_range(0, 1));
        step();
        return;
      end
      step();
    end
  endtask

  task automatic illegal_cmd(input logic [2:0] job, input logic [1:0] lvl);
    cmd_valid = 1'b1;
    cmd_job   = job;
    cmd_level = lvl;
    exp_q.push_back(mk(K_ERR, job, lvl, 0, cyc + 1, 0));
    step();
    cmd_valid = 1'b0;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_hash_ready"}, 32'(hash_ready), 32'd0);
    chk({tag, "_agu_addr_clr"}, 32'(agu_addr_clr), 32'd0);
    chk({tag, "_agu_add_en"}, 32'(agu_add_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_agu_mode"}, 32'(agu_mode), 32'd0);
    chk({tag, "_agu_level"}, 32'(agu_level), 32'd0);
`ifdef HASH_SCHED_PERF_EN
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] jobs [4];
    logic [2:0] j;
    logic [1:0] l;
    int len, ab;
    jobs[0] = 3'b000;
    jobs[1] = 3'b001;
    jobs[2] = 3'b100;
    jobs[3] = 3'b101;
    rstn = 1'b1;
    cmd_valid = 1'b0;
    cmd_abort = 1'b0;
    cmd_job = 3'd0;
    cmd_level = 2'd0;
    hash_valid = 1'b0;
    mem_stall = 1'b0;
    #1 rstn = 1'b0;
    #7;
    check_reset_outputs("reset");
    step();
    rstn = 1'b1;
    step();

    run_job(3'b001, 2'b11, -1, 0, 0, 1'b0, 1'b0);
    run_job(3'b000, 2'b01, -1, 0, 1, 1'b0, 1'b0);
    run_job(3'b101, 2'b10, 100, 1, 2, 1'b0, 1'b0);
    step();
    illegal_cmd(3'b001, 2'b00);
    illegal_cmd(3'b010, 2'b01);
    illegal_cmd(3'b111, 2'b11);
    run_job(3'b100, 2'b11, -1, 1, 2, 1'b1, 1'b0);
    run_job(3'b001, 2'b10, -1, 1, 0, 1'b0, 1'b1);
    run_job(3'b100, 2'b11, -1, 2, 0, 1'b0, 1'b0);
    run_job(3'b000, 2'b11, 0, 1, 2, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      j = jobs[$urandom_range(0, 3)];
      l = 2'($urandom_range(1, 3));
      len = model_len(j, l);
      ab = (len > 1400) ? $urandom_range(0, 200) : -1;
      run_job(j, l, ab, 1, 2, 1'b1, 1'($urandom_range(0, 1)));
    end

    cmd_valid = 1'b1;
    cmd_job = 3'b001;
    cmd_level = 2'b11;
    step();
    cmd_valid = 1'b0;
    hash_valid = 1'b1;
    repeat (12) step();
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    step();
    rstn = 1'b1;
    hash_valid = 1'b0;
    step();

    run_job(3'b001, 2'b01, -1, 1, 1, 1'b0, 1'b0);
    repeat (4) step();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
